// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: sweeps select 0..7 with a programmable
// enable-high dwell per address and an optional enable-low blanking gap.
module dec_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         a,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam logic [3:0] BLANK_LD  = 4'(BLANK_CYC);
    localparam bit         HAS_BLANK = (BLANK_CYC > 0);

    state_t             state, state_n;
    logic [2:0]         a_n;
    logic               done_n;
    logic               mode_q, mode_q_n;
    logic [DWELL_W-1:0] dwell_q, dwell_q_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [3:0]         bcnt, bcnt_n;
    logic [DWELL_W-1:0] dwell_eff;

    // A zero dwell would never terminate the countdown, so it runs as one cycle.
    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_comb begin
        state_n   = state;
        a_n       = a;
        done_n    = 1'b0;
        mode_q_n  = mode_q;
        dwell_q_n = dwell_q;
        cnt_n     = cnt;
        bcnt_n    = bcnt;

        case (state)
            IDLE: begin
                a_n = 3'd0;
                if (start) begin
                    dwell_q_n = dwell_eff;
                    mode_q_n  = mode_cont;
                    if (HAS_BLANK) begin
                        state_n = BLANK;
                        bcnt_n  = BLANK_LD;
                    end else begin
                        state_n = DRIVE;
                        cnt_n   = dwell_eff;
                    end
                end
            end

            BLANK: begin
                if (stop) begin
                    state_n = IDLE;
                    a_n     = 3'd0;
                    cnt_n   = '0;
                    bcnt_n  = '0;
                end else if (bcnt == 4'd1) begin
                    state_n = DRIVE;
                    bcnt_n  = '0;
                    cnt_n   = dwell_q;
                end else begin
                    bcnt_n = bcnt - 4'd1;
                end
            end

            DRIVE: begin
                if (stop) begin
                    state_n = IDLE;
                    a_n     = 3'd0;
                    cnt_n   = '0;
                    bcnt_n  = '0;
                end else if (cnt == DWELL_W'(1)) begin
                    if (a == 3'd7 && !mode_q) begin
                        state_n = IDLE;
                        a_n     = 3'd0;
                        done_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        // 3-bit increment wraps 7 -> 0 in continuous mode
                        a_n = a + 3'd1;
                        if (HAS_BLANK) begin
                            state_n = BLANK;
                            bcnt_n  = BLANK_LD;
                        end else begin
                            state_n = DRIVE;
                            cnt_n   = dwell_q;
                        end
                    end
                end else begin
                    cnt_n = cnt - DWELL_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                a_n     = 3'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= 3'd0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mode_q  <= 1'b0;
            dwell_q <= '0;
            cnt     <= '0;
            bcnt    <= '0;
        end else begin
            state   <= state_n;
            a       <= a_n;
            en      <= (state_n == DRIVE);
            busy    <= (state_n != IDLE);
            done    <= done_n;
            mode_q  <= mode_q_n;
            dwell_q <= dwell_q_n;
            cnt     <= cnt_n;
            bcnt    <= bcnt_n;
        end
    end

endmodule
